// File: rtl/softmax_q610_pkg.sv
// Shared Q6.10 fixed-point constants for the softmax datapath.
package softmax_q610_pkg;

  localparam int Q610_DATA_W = 16;
  localparam int Q610_FRAC_W = 10;
  localparam int Q610_INT_W  = Q610_DATA_W - Q610_FRAC_W;

  // Most negative Q6.10 value, used as the log2(0) saturation code.
  localparam logic [Q610_DATA_W-1:0] Q610_NEG_SAT = 16'h8000;
  // 1.0 in Q6.10.
  localparam logic [Q610_DATA_W-1:0] Q610_ONE     = 16'h0400;

endpackage : softmax_q610_pkg

// File: rtl/leading_one_detector.sv
// Combinational leading-one detector: index of the most-significant set bit
// plus an all-zero flag. Index reads 0 when the operand is zero.
module leading_one_detector #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] x,
  output logic [IDX_W-1:0]  idx,
  output logic              zero
);

  // Priority scan from LSB upward; the last set bit seen wins.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (x[i]) idx = IDX_W'(i);
    end
  end

  assign zero = ~|x;

endmodule : leading_one_detector

// File: rtl/stage4_log2_approx.sv
// Three-stage pipelined base-2 logarithm (Mitchell approximation) for
// unsigned Q6.10 operands, producing signed Q6.10 results.
// Optional build macro: LOG2_CORR_EN enables piecewise-linear error
// correction of the mantissa in the last stage (latency unchanged).
module stage4_log2_approx
  import softmax_q610_pkg::*;
#(
  parameter int DATA_W = Q610_DATA_W,
  parameter int FRAC_W = Q610_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in_x,
  output logic              valid_out,
  output logic [DATA_W-1:0] log2_out,
  output logic [DATA_W-1:0] in_x_bypass,
  output logic              zero_out
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int INT_W = DATA_W - FRAC_W;

  localparam logic [DATA_W-1:0] NEG_SAT = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------------------------------------------------------- S1
  logic [IDX_W-1:0]  lod_idx;
  logic              lod_zero;

  logic              v1;
  logic [DATA_W-1:0] x1;
  logic [IDX_W-1:0]  p1;
  logic              z1;

  leading_one_detector #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_lod (
    .x    (in_x),
    .idx  (lod_idx),
    .zero (lod_zero)
  );

  // Capture operand, leading-one index and zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      x1 <= '0;
      p1 <= '0;
      z1 <= 1'b0;
    end else if (en) begin
      v1 <= valid_in;
      x1 <= in_x;
      p1 <= lod_idx;
      z1 <= lod_zero;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [INT_W-1:0]  k_next;
  logic [FRAC_W-1:0] m_next;

  logic              v2;
  logic [DATA_W-1:0] x2;
  logic [INT_W-1:0]  k2;
  logic [FRAC_W-1:0] m2;
  logic              z2;

  // Characteristic and mantissa. The mantissa is the FRAC_W bits directly
  // below the leading one; appending FRAC_W zeros and shifting right by p
  // yields the same bits as left-aligning the operand and slicing below
  // the MSB, without leaving unused shifter bits behind.
  always_comb begin
    k_next = INT_W'(p1) - INT_W'(FRAC_W);
    m_next = FRAC_W'({x1, {FRAC_W{1'b0}}} >> p1);
  end

  // Register characteristic, mantissa and the carried fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      x2 <= '0;
      k2 <= '0;
      m2 <= '0;
      z2 <= 1'b0;
    end else if (en) begin
      v2 <= v1;
      x2 <= x1;
      k2 <= k_next;
      m2 <= m_next;
      z2 <= z1;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [FRAC_W-1:0] m_adj;
  logic [DATA_W-1:0] result;

  // Mantissa correction (optional) and final assembly with zero saturation.
`ifdef LOG2_CORR_EN
  logic [FRAC_W-1:0] corr;

  always_comb begin
    // 2^FRAC_W-1-m is the bitwise complement of m.
    corr   = m2[FRAC_W-1] ? ((~m2) >> 3) : (m2 >> 3);
    m_adj  = m2 + corr;
    result = z2 ? NEG_SAT : {k2, m_adj};
  end
`else
  always_comb begin
    m_adj  = m2;
    result = z2 ? NEG_SAT : {k2, m_adj};
  end
`endif

  // Output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out   <= 1'b0;
      log2_out    <= '0;
      in_x_bypass <= '0;
      zero_out    <= 1'b0;
    end else if (en) begin
      valid_out   <= v2;
      log2_out    <= result;
      in_x_bypass <= x2;
      zero_out    <= z2;
    end
  end

endmodule : stage4_log2_approx

// File: tb/tb_stage4_log2_approx.sv
// Scoreboard bench for stage4_log2_approx. Expected results are computed by
// an arithmetic reference model when a sample is driven and compared when
// the DUT presents it.
module tb_stage4_log2_approx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic [15:0] in_x;
  logic        valid_out;
  logic [15:0] log2_out;
  logic [15:0] in_x_bypass;
  logic        zero_out;

  typedef struct {
    logic [15:0] log2;
    logic [15:0] x;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  logic last_v;

  int checks;
  int errors;

  stage4_log2_approx #(
    .DATA_W (16),
    .FRAC_W (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .valid_in    (valid_in),
    .in_x        (in_x),
    .valid_out   (valid_out),
    .log2_out    (log2_out),
    .in_x_bypass (in_x_bypass),
    .zero_out    (zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: log2(x) = p + (x - 2^p)/2^p, scaled to Q6.10.
  function automatic logic [15:0] ref_log2(input logic [15:0] x);
    int p;
    int m;
    int k;
    int c;
    if (x == 16'h0000) return 16'h8000;
    p = 15;
    while (!x[p]) p--;
    if (p >= 10) m = (int'(x) - (1 << p)) >>> (p - 10);
    else         m = (int'(x) - (1 << p)) << (10 - p);
    k = p - 10;
`ifdef LOG2_CORR_EN
    c = (m < 512) ? (m >> 3) : ((1023 - m) >> 3);
    m = m + c;
`else
    c = 0;
    m = m + c;
`endif
    return 16'(k * 1024 + m);
  endfunction

  task automatic drive(input logic [15:0] x, input logic v, input logic e);
    exp_t t;
    @(negedge clk);
    in_x     = x;
    valid_in = v;
    en       = e;
    if (v && e) begin
      t.log2 = ref_log2(x);
      t.x    = x;
      t.z    = (x == 16'h0000);
      exp_q.push_back(t);
    end
  endtask

  // Output monitor: compares on enabled edges, checks freeze on stalled ones.
  initial begin
    logic en_s;
    logic rst_s;
    exp_t t;
    last_v = 1'b0;
    forever begin
      @(posedge clk);
      en_s  = en;
      rst_s = rst;
      #1;
      if (!rst_s && !rst) begin
        if (en_s) begin
          if (valid_out) begin
            if (exp_q.size() == 0) begin
              check("spurious_valid", {31'd0, valid_out}, 32'd0);
            end else begin
              t = exp_q.pop_front();
              check("log2_out", {16'd0, log2_out}, {16'd0, t.log2});
              check("bypass", {16'd0, in_x_bypass}, {16'd0, t.x});
              check("zero_out", {31'd0, zero_out}, {31'd0, t.z});
              last_exp = t;
              last_v   = 1'b1;
            end
          end else begin
            last_v = 1'b0;
          end
        end else begin
          check("stall_valid", {31'd0, valid_out}, {31'd0, last_v});
          if (last_v)
            check("stall_log2", {16'd0, log2_out}, {16'd0, last_exp.log2});
        end
      end
    end
  end

  initial begin
    logic [15:0] stream [8];
    int budget;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    valid_in = 1'b0;
    in_x     = 16'h0000;
    #12;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_log2", {16'd0, log2_out}, 32'd0);
    check("rst_bypass", {16'd0, in_x_bypass}, 32'd0);
    check("rst_zero", {31'd0, zero_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1.0 with explicit latency checks.
    drive(16'h0400, 1'b1, 1'b1);
    drive(16'h0000, 1'b0, 1'b1);
    check("lat_edge1", {31'd0, valid_out}, 32'd0);
    drive(16'h0000, 1'b0, 1'b1);
    check("lat_edge2", {31'd0, valid_out}, 32'd0);
    drive(16'h0000, 1'b0, 1'b1);
    check("lat_edge3", {31'd0, valid_out}, 32'd1);
    check("one_const", {16'd0, log2_out}, 32'h0000);

    // Power-of-two, extremes, 1.5, zero followed by 1.0.
    drive(16'h0800, 1'b1, 1'b1);
    drive(16'h0100, 1'b1, 1'b1);
    drive(16'h0001, 1'b1, 1'b1);
    drive(16'hFFFF, 1'b1, 1'b1);
    drive(16'h0600, 1'b1, 1'b1);
    drive(16'h0000, 1'b1, 1'b1);
    drive(16'h0400, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(16'h1234, 1'b0, 1'b1);

    // Fixed-value sanity against hand-derived constants.
    check("max_const", {16'd0, ref_log2(16'hFFFF)}, 32'h17FF);
    check("min_const", {16'd0, ref_log2(16'h0001)}, 32'hD800);
`ifdef LOG2_CORR_EN
    check("half_const", {16'd0, ref_log2(16'h0600)}, 32'h023F);
`else
    check("half_const", {16'd0, ref_log2(16'h0600)}, 32'h0200);
`endif

    // Back-to-back stream with a two-cycle stall in the middle.
    for (int i = 0; i < 8; i++) stream[i] = 16'($urandom_range(1, 16'hFFFF));
    for (int i = 0; i < 4; i++) drive(stream[i], 1'b1, 1'b1);
    drive(stream[4], 1'b1, 1'b0);
    drive(stream[4], 1'b1, 1'b0);
    for (int i = 4; i < 8; i++) drive(stream[i], 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(16'h0000, 1'b0, 1'b1);

    // Random samples with occasional invalid slots.
    for (int i = 0; i < 24; i++)
      drive(16'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    for (int i = 0; i < 5; i++) drive(16'h0000, 1'b0, 1'b1);

    // Reset with samples in flight.
    drive(16'h0400, 1'b1, 1'b1);
    drive(16'h0800, 1'b1, 1'b1);
    drive(16'h0C00, 1'b1, 1'b1);
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    #1;
    exp_q.delete();
    last_v = 1'b0;
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_log2", {16'd0, log2_out}, 32'd0);
    check("midrst_bypass", {16'd0, in_x_bypass}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(16'h0000, 1'b0, 1'b1);
      check("postrst_idle", {31'd0, valid_out}, 32'd0);
    end
    drive(16'h0200, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(16'h0000, 1'b0, 1'b1);

    // Bounded drain.
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stage4_log2_approx
